i2c_target: RTL
===============

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter ADDRESS, default 7'h50, the 7-bit target address matched on the bus.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on sclIn/sdaIn.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic rises on clk.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sclIn, input, 1, raw SCL pin level (asynchronous).
REQ-006 SHALL have port sdaIn, input, 1, raw SDA pin level (asynchronous).
REQ-007 SHALL have port sdaDriveLow, output, 1; 1 pulls SDA low, 0 releases it (the top level builds the open-drain buffer).
REQ-008 SHALL have port txByte, input, 8, next byte returned to the controller on reads.
REQ-009 SHALL have port txRequest, output, 1, one-cycle pulse requesting txByte.
REQ-010 SHALL have port rxByte, output, 8, last byte written by the controller.
REQ-011 SHALL have port rxValid, output, 1, one-cycle pulse when rxByte updates.
REQ-012 SHALL have port busy, output, 1, high while addressed (ADDR_ACK through end of transfer).

Function
REQ-013 SHALL synchronize sclIn/sdaIn through SYNC_STAGES flops and derive one-cycle sclRise/sclFall strobes from the synchronized levels.
REQ-014 SHALL detect START as synchronized SDA falling while SCL high, and STOP as SDA rising while SCL high.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
REQ-016 SHALL, on START in any state (incl. repeated START), enter ADDR with bit counter 0 and sdaDriveLow 0 the next cycle.
REQ-017 SHALL, on STOP in any state, enter IDLE and release SDA the next cycle.
REQ-018 SHALL sample SDA on sclRise and change sdaDriveLow only in the cycle after sclFall.
REQ-019 ADDR: shift 8 bits MSB first; on the sclFall after bit 8, on address match enter ADDR_ACK driving low, else enter WAIT_STOP with SDA released.
REQ-020 ADDR_ACK: on sclFall release SDA; if R/W=0 go RX_BYTE; if R/W=1 latch txByte, drive bit 7, go TX_BYTE.
REQ-021 txRequest SHALL pulse in the cycle ADDR_ACK is entered for reads and in the cycle a host ACK is sampled in TX_ACK; txByte must be stable by the following sclFall.
REQ-022 RX_BYTE: on 8th sclRise update rxByte and pulse rxValid that cycle; on the next sclFall drive ACK (enter RX_ACK); on the sclFall after that release and return to RX_BYTE.
REQ-023 TX_BYTE: drive low exactly when the current bit is 0; after the 8th bit's sclFall release SDA and enter TX_ACK.
REQ-024 TX_ACK: on sclRise, SDA=0 (ACK) -> pulse txRequest, latch txByte at next sclFall, re-enter TX_BYTE; SDA=1 (NACK) -> WAIT_STOP.
REQ-025 WAIT_STOP SHALL keep SDA released and leave only on START or STOP.
REQ-026 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary.
REQ-027 SHALL operate correctly when clk is at least 16x the SCL frequency; simultaneous START and sclFall SHALL give START priority.
REQ-028 The block SHALL never drive SDA while synchronized SCL is high except across a bit already being held.

Reset
REQ-029 On reset: state IDLE, sdaDriveLow 0, txRequest 0, rxValid 0, busy 0, rxByte 8'h00, counters 0, synchronizer flops 1.
REQ-030 Reset mid-transaction SHALL release SDA the cycle after reset is sampled; the block ignores the bus until the next START.

Structure
REQ-031 State encodings and the 7-bit default address SHALL live in shared package i2c_pkg, used also by the controller.
REQ-032 SHALL instantiate one sub-module i2c_bus_sync (synchronizers, edge strobes, START/STOP detect).

Verification
REQ-033 Write 0xA0 (addr 0x50,W), data 0x3C, STOP -> ACK on both bytes, one rxValid with rxByte=0x3C, busy low after STOP.
REQ-034 Read 0xA1, txByte=0x96 then 0x5A, host ACK then NACK -> SDA shows 10010110,01011010; two txRequest pulses; WAIT_STOP after NACK.
REQ-035 Address 0x51 write -> sdaDriveLow stays 0 for whole frame, no rxValid, busy 0.
REQ-036 Write 0x11 then repeated START, read -> rxByte=0x11, ADDR re-entered, read proceeds with ACK.
REQ-037 Reset asserted during TX bit 3 with SDA driven low -> sdaDriveLow 0 next cycle, no response until next START.
REQ-038 STOP injected mid RX_BYTE after 4 bits -> IDLE, no rxValid, SDA released.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target and controller blocks.
// Contents:
//   DEFAULT_ADDRESS - 7-bit bus address used when no override is given
//   BIT_CNT_W       - width of the per-byte bit counter (wraps 7 -> 0)
//   i2c_state_t     - protocol state encoding
//   addr_match()    - compares the address field of a received frame byte
package i2c_pkg;

    localparam logic [6:0] DEFAULT_ADDRESS = 7'h50;
    localparam int         BIT_CNT_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_BYTE,
        RX_ACK,
        TX_BYTE,
        TX_ACK,
        WAIT_STOP
    } i2c_state_t;

    // Address frame is {addr[6:0], rw}; only the upper seven bits identify the target.
    function automatic logic addr_match(input logic [7:0] frame, input logic [6:0] addr);
        return frame[7:1] == addr;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the raw SCL/SDA pins into the clk domain and derives bus events.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   scl_pin, sda_pin      - raw asynchronous pin levels
//   sda_level             - synchronized SDA level
//   scl_rise, scl_fall    - one-cycle strobes on synchronized SCL edges
//   start_det, stop_det   - one-cycle strobes for START / STOP conditions
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_prev_reg;
    logic                   sda_prev_reg;
    logic                   scl_now;
    logic                   sda_now;

    assign scl_now = scl_sync_reg[SYNC_STAGES-1];
    assign sda_now = sda_sync_reg[SYNC_STAGES-1];

    // Flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_reg <= '1;
            sda_sync_reg <= '1;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg[0] <= scl_pin;
            sda_sync_reg[0] <= sda_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                scl_sync_reg[i] <= scl_sync_reg[i-1];
                sda_sync_reg[i] <= sda_sync_reg[i-1];
            end
            scl_prev_reg <= scl_now;
            sda_prev_reg <= sda_now;
        end
    end

    assign sda_level = sda_now;
    assign scl_rise  = scl_now & ~scl_prev_reg;
    assign scl_fall  = ~scl_now & scl_prev_reg;
    // SCL must be high on both samples so an SDA change next to an SCL edge is not misread.
    assign start_det = scl_now & scl_prev_reg & sda_prev_reg & ~sda_now;
    assign stop_det  = scl_now & scl_prev_reg & ~sda_prev_reg & sda_now;

endmodule

// File: rtl/i2c_target.sv
// I2C target (slave) protocol engine with a single 7-bit address.
// Ports:
//   clk, reset   - system clock, synchronous active-high reset
//   sclIn, sdaIn - raw bus pin levels
//   sdaDriveLow  - 1 pulls SDA low, 0 releases it
//   txByte       - byte returned on reads, sampled after a txRequest pulse
//   txRequest    - one-cycle request for the next txByte
//   rxByte       - last byte written by the controller
//   rxValid      - one-cycle pulse when rxByte updates
//   busy         - high from address acknowledge until the transfer ends
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS     = DEFAULT_ADDRESS,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sdaDriveLow,
    input  logic [7:0] txByte,
    output logic       txRequest,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       busy
);

    logic sda_level, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .clk      (clk),
        .reset    (reset),
        .scl_pin  (sclIn),
        .sda_pin  (sdaIn),
        .sda_level(sda_level),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_state_t           state_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [7:0]           shift_reg;     // incoming address / write data
    logic [6:0]           tx_reg;        // read bits still to be driven, MSB next
    logic                 byte_done_reg; // 8 bits clocked, waiting for the closing sclFall
    logic                 host_ack_reg;  // controller ACKed, reload on the next sclFall
    logic                 drive_reg;
    logic                 tx_req_reg;
    logic                 rx_valid_reg;
    logic                 busy_reg;
    logic [7:0]           rx_byte_reg;

    assign sdaDriveLow = drive_reg;
    assign txRequest   = tx_req_reg;
    assign rxValid     = rx_valid_reg;
    assign busy        = busy_reg;
    assign rxByte      = rx_byte_reg;

    // SDA only changes on sclFall, so the block never disturbs SDA while SCL is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            tx_reg        <= '0;
            byte_done_reg <= 1'b0;
            host_ack_reg  <= 1'b0;
            drive_reg     <= 1'b0;
            tx_req_reg    <= 1'b0;
            rx_valid_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            rx_byte_reg   <= '0;
        end else begin
            tx_req_reg   <= 1'b0;
            rx_valid_reg <= 1'b0;
            // START outranks everything, including a coincident sclFall.
            if (start_det || stop_det) begin
                state_reg     <= start_det ? ADDR : IDLE;
                bit_cnt_reg   <= '0;
                byte_done_reg <= 1'b0;
                host_ack_reg  <= 1'b0;
                drive_reg     <= 1'b0;
                busy_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_level};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (&bit_cnt_reg) byte_done_reg <= 1'b1;
                        end else if (scl_fall && byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            if (addr_match(shift_reg, ADDRESS)) begin
                                state_reg  <= ADDR_ACK;
                                drive_reg  <= 1'b1;
                                busy_reg   <= 1'b1;
                                tx_req_reg <= shift_reg[0];
                            end else begin
                                state_reg <= WAIT_STOP;
                                drive_reg <= 1'b0;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt_reg <= '0;
                            if (shift_reg[0]) begin
                                tx_reg    <= txByte[6:0];
                                drive_reg <= ~txByte[7];
                                state_reg <= TX_BYTE;
                            end else begin
                                drive_reg <= 1'b0;
                                state_reg <= RX_BYTE;
                            end
                        end
                    end
                    RX_BYTE: begin
                        if (scl_rise) begin
                            shift_reg   <= {shift_reg[6:0], sda_level};
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (&bit_cnt_reg) begin
                                rx_byte_reg   <= {shift_reg[6:0], sda_level};
                                rx_valid_reg  <= 1'b1;
                                byte_done_reg <= 1'b1;
                            end
                        end else if (scl_fall && byte_done_reg) begin
                            byte_done_reg <= 1'b0;
                            drive_reg     <= 1'b1;
                            state_reg     <= RX_ACK;
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            drive_reg   <= 1'b0;
                            bit_cnt_reg <= '0;
                            state_reg   <= RX_BYTE;
                        end
                    end
                    TX_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (&bit_cnt_reg) byte_done_reg <= 1'b1;
                        end else if (scl_fall) begin
                            if (byte_done_reg) begin
                                byte_done_reg <= 1'b0;
                                host_ack_reg  <= 1'b0;
                                drive_reg     <= 1'b0;
                                state_reg     <= TX_ACK;
                            end else begin
                                drive_reg <= ~tx_reg[6];
                                tx_reg    <= {tx_reg[5:0], 1'b0};
                            end
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!sda_level) begin
                                host_ack_reg <= 1'b1;
                                tx_req_reg   <= 1'b1;
                            end else begin
                                state_reg <= WAIT_STOP;
                            end
                        end else if (scl_fall && host_ack_reg) begin
                            host_ack_reg <= 1'b0;
                            bit_cnt_reg  <= '0;
                            tx_reg       <= txByte[6:0];
                            drive_reg    <= ~txByte[7];
                            state_reg    <= TX_BYTE;
                        end
                    end
                    default: begin
                        // IDLE and WAIT_STOP: SDA stays released until START/STOP.
                        drive_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
